// File: rtl/zone_buf_scheduler.sv
// Ping-pong zone buffer between the backlight algorithm and the MiniLED driver.
// Banks swap only on a reader sync after a completed frame; reads are gain-scaled.
module zone_buf_scheduler #(
   parameter int unsigned ZONES = 360,
   parameter int unsigned DW    = 8,
   parameter int unsigned AW    = 9
) (
   input  logic          I_clk,
   input  logic          I_rst_n,
   input  logic          I_wr_valid,
   input  logic [AW-1:0] I_wr_idx,
   input  logic [DW-1:0] I_wr_data,
   input  logic          I_wr_done,
   input  logic          I_rd_sync,
   input  logic          I_rd_req,
   input  logic [AW-1:0] I_rd_idx,
   input  logic [7:0]    I_gain,
   output logic          O_rd_valid,
   output logic [DW-1:0] O_rd_data,
   output logic          O_rd_bank,
   output logic          O_swap,
   output logic          O_overrun,
   output logic [7:0]    O_frame_cnt
);

   localparam logic [AW-1:0] ZONE_LIM = AW'(ZONES);

   typedef enum logic {
      FILL  = 1'b0,
      READY = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic          rd_bank_q;
   logic          bank_ok_q;
   logic          swap_q, swap_d;
   logic          overrun_q, overrun_d;
   logic          wr_en;
   logic [7:0]    frame_cnt_q;

   logic [DW-1:0] bank0_q [ZONES];
   logic [DW-1:0] bank1_q [ZONES];

   logic          rd_in_range;
   logic [AW-1:0] rd_addr;
   logic          req1_q, zero1_q;
   logic [7:0]    gain1_q;
   logic [DW-1:0] raw1_q;
   logic          rd_valid_q;
   logic [DW-1:0] rd_data_q;
   logic [DW-1:0] scaled;

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q     <= FILL;
         rd_bank_q   <= 1'b0;
         bank_ok_q   <= 1'b0;
         swap_q      <= 1'b0;
         overrun_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         swap_q    <= swap_d;
         overrun_q <= overrun_d;
         if (swap_d) begin
            rd_bank_q   <= ~rd_bank_q;
            bank_ok_q   <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 8'd1;
         end
      end
   end

   // A sync arriving with wr_done in FILL only arms READY; the swap needs a later sync.
   always_comb begin
      state_d   = state_q;
      swap_d    = 1'b0;
      overrun_d = 1'b0;
      wr_en     = 1'b0;
      case (state_q)
         FILL: begin
            wr_en = I_wr_valid && (I_wr_idx < ZONE_LIM);
            if (I_wr_done) state_d = READY;
         end
         READY: begin
            overrun_d = I_wr_valid || I_wr_done;
            if (I_rd_sync) begin
               swap_d  = 1'b1;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (wr_en) begin
         if (rd_bank_q) bank0_q[I_wr_idx] <= I_wr_data;
         else           bank1_q[I_wr_idx] <= I_wr_data;
      end
   end

   assign rd_in_range = (I_rd_idx < ZONE_LIM);
   assign rd_addr     = rd_in_range ? I_rd_idx : '0;

   // Bank select is taken at request time, so a later swap cannot disturb the read.
   always_ff @(posedge I_clk) begin
      raw1_q <= rd_bank_q ? bank1_q[rd_addr] : bank0_q[rd_addr];
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         req1_q  <= 1'b0;
         zero1_q <= 1'b0;
         gain1_q <= '0;
      end else begin
         req1_q  <= I_rd_req;
         zero1_q <= !rd_in_range || !bank_ok_q;
         gain1_q <= I_gain;
      end
   end

   always_comb begin
      if (gain1_q == 8'hFF) scaled = raw1_q;
      else scaled = DW'(((DW+8)'(raw1_q) * (DW+8)'(gain1_q) + (DW+8)'(128)) >> 8);
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= req1_q;
         if (req1_q) rd_data_q <= zero1_q ? '0 : scaled;
      end
   end

   assign O_rd_valid  = rd_valid_q;
   assign O_rd_data   = rd_data_q;
   assign O_rd_bank   = rd_bank_q;
   assign O_swap      = swap_q;
   assign O_overrun   = overrun_q;
   assign O_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_zone_buf_scheduler.sv
// Randomized bench for zone_buf_scheduler against a frame-level reference model.
module tb_zone_buf_scheduler;

   localparam int ZONES = 360;
   localparam int DW    = 8;
   localparam int AW    = 9;

   logic          I_clk = 1'b0;
   logic          I_rst_n = 1'b0;
   logic          I_wr_valid = 1'b0;
   logic [AW-1:0] I_wr_idx = '0;
   logic [DW-1:0] I_wr_data = '0;
   logic          I_wr_done = 1'b0;
   logic          I_rd_sync = 1'b0;
   logic          I_rd_req = 1'b0;
   logic [AW-1:0] I_rd_idx = '0;
   logic [7:0]    I_gain = 8'd255;
   logic          O_rd_valid;
   logic [DW-1:0] O_rd_data;
   logic          O_rd_bank;
   logic          O_swap;
   logic          O_overrun;
   logic [7:0]    O_frame_cnt;

   zone_buf_scheduler #(.ZONES(ZONES), .DW(DW), .AW(AW)) dut (
      .I_clk(I_clk), .I_rst_n(I_rst_n),
      .I_wr_valid(I_wr_valid), .I_wr_idx(I_wr_idx), .I_wr_data(I_wr_data),
      .I_wr_done(I_wr_done), .I_rd_sync(I_rd_sync),
      .I_rd_req(I_rd_req), .I_rd_idx(I_rd_idx), .I_gain(I_gain),
      .O_rd_valid(O_rd_valid), .O_rd_data(O_rd_data), .O_rd_bank(O_rd_bank),
      .O_swap(O_swap), .O_overrun(O_overrun), .O_frame_cnt(O_frame_cnt)
   );

   always #5 I_clk = ~I_clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference model: frame-level view of both banks and the display side.
   int mem [2][ZONES];
   bit m_ready = 0;
   int m_disp = 0;
   int m_frames = 0;
   bit m_ok = 0;
   bit p1_v = 0;
   int p1_d = 0;
   bit o_v = 0;
   int o_d = 0;
   bit e_swap = 0;
   bit e_ovr = 0;

   function automatic int scale(input int raw, input int g);
      if (g == 255) return raw;
      return (raw * g + 128) / 256;
   endfunction

   task automatic model_reset();
      m_ready = 0; m_disp = 0; m_frames = 0; m_ok = 0;
      p1_v = 0; p1_d = 0; o_v = 0; o_d = 0; e_swap = 0; e_ovr = 0;
   endtask

   task automatic clear_strobes();
      I_wr_valid = 0; I_wr_done = 0; I_rd_sync = 0; I_rd_req = 0;
   endtask

   // One clock of the current inputs: advance the model, clock the DUT, compare.
   task automatic cycle();
      bit nv;
      int nd;
      e_swap = m_ready && I_rd_sync;
      e_ovr  = m_ready && (I_wr_valid || I_wr_done);
      nv = I_rd_req;
      nd = 0;
      if (I_rd_req && int'(I_rd_idx) < ZONES && m_ok)
         nd = scale(mem[m_disp][int'(I_rd_idx)], int'(I_gain));
      if (!m_ready) begin
         if (I_wr_valid && int'(I_wr_idx) < ZONES) mem[1 - m_disp][int'(I_wr_idx)] = int'(I_wr_data);
         if (I_wr_done) m_ready = 1;
      end else if (I_rd_sync) begin
         m_disp = 1 - m_disp;
         m_frames = (m_frames + 1) % 256;
         m_ok = 1;
         m_ready = 0;
      end
      o_v = p1_v;
      if (p1_v) o_d = p1_d;
      p1_v = nv;
      p1_d = nd;
      @(posedge I_clk);
      #1;
      chk("swap", O_swap, e_swap);
      chk("overrun", O_overrun, e_ovr);
      chk("rd_bank", O_rd_bank, m_disp);
      chk("frame_cnt", O_frame_cnt, m_frames);
      chk("rd_valid", O_rd_valid, o_v);
      chk("rd_data", O_rd_data, o_d);
      clear_strobes();
   endtask

   task automatic rd(input int idx);
      I_rd_req = 1;
      I_rd_idx = AW'(idx);
      cycle();
      cycle();
   endtask

   task automatic fill(input bit ramp);
      for (int i = 0; i < ZONES; i++) begin
         I_wr_valid = 1;
         I_wr_idx = AW'(i);
         I_wr_data = ramp ? DW'(i % 256) : DW'($urandom_range(0, 255));
         cycle();
      end
   endtask

   task automatic rand_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         I_wr_valid = ($urandom_range(0, 3) != 0);
         I_wr_idx   = AW'($urandom_range(0, 400));
         I_wr_data  = DW'($urandom_range(0, 255));
         I_wr_done  = ($urandom_range(0, 199) == 0);
         I_rd_sync  = ($urandom_range(0, 59) == 0);
         I_rd_req   = $urandom_range(0, 1);
         I_rd_idx   = AW'($urandom_range(0, 380));
         if ($urandom_range(0, 15) == 0)
            I_gain = ($urandom_range(0, 2) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
         cycle();
      end
   endtask

   task automatic async_reset_mid_write();
      I_wr_valid = 1;
      I_wr_idx = AW'(17);
      I_wr_data = 8'hA5;
      #2;
      I_rst_n = 0;
      clear_strobes();
      #1;
      chk("arst_rd_valid", O_rd_valid, 0);
      chk("arst_rd_data", O_rd_data, 0);
      chk("arst_rd_bank", O_rd_bank, 0);
      chk("arst_swap", O_swap, 0);
      chk("arst_overrun", O_overrun, 0);
      chk("arst_frame_cnt", O_frame_cnt, 0);
      model_reset();
      @(posedge I_clk);
      #1;
      I_rst_n = 1;
   endtask

   initial begin
      int old_exp;
      repeat (3) @(posedge I_clk);
      #1;
      I_rst_n = 1;
      model_reset();
      chk("rst_rd_valid", O_rd_valid, 0);
      chk("rst_rd_data", O_rd_data, 0);
      chk("rst_rd_bank", O_rd_bank, 0);
      chk("rst_swap", O_swap, 0);
      chk("rst_overrun", O_overrun, 0);
      chk("rst_frame_cnt", O_frame_cnt, 0);

      I_gain = 8'd255;
      rd(5);
      chk("nobank_valid", O_rd_valid, 1);
      chk("nobank_data", O_rd_data, 0);

      fill(1'b1);
      I_wr_done = 1; cycle();
      cycle();
      I_rd_sync = 1; cycle();
      chk("first_swap", O_swap, 1);
      chk("first_bank", O_rd_bank, 1);
      chk("first_cnt", O_frame_cnt, 1);
      rd(10);  chk("rd_idx10", O_rd_data, 10);
      rd(300); chk("rd_idx300", O_rd_data, 44);
      I_gain = 8'd128;
      rd(200); chk("rd_gain128", O_rd_data, 100);
      rd(360);
      chk("rd_oob_valid", O_rd_valid, 1);
      chk("rd_oob_data", O_rd_data, 0);

      fill(1'b0);
      I_wr_done = 1; cycle();
      I_wr_valid = 1; I_wr_idx = AW'(3); I_wr_data = 8'h5A; cycle();
      chk("ovr_write", O_overrun, 1);
      I_wr_done = 1; cycle();
      chk("ovr_done", O_overrun, 1);
      I_rd_sync = 1; cycle();
      I_gain = 8'd255;
      for (int i = 0; i < 8; i++) rd($urandom_range(0, ZONES - 1));

      for (int i = 0; i < 20; i++) begin
         I_wr_valid = 1; I_wr_idx = AW'(i); I_wr_data = DW'($urandom_range(0, 255)); cycle();
      end
      I_wr_done = 1; I_rd_sync = 1; cycle();
      cycle();
      chk("no_same_cycle_swap", O_swap, 0);
      I_gain = 8'd200;
      old_exp = scale(mem[m_disp][7], 200);
      I_rd_req = 1; I_rd_idx = AW'(7); cycle();
      I_rd_sync = 1; I_wr_valid = 1; I_wr_idx = AW'(7); I_wr_data = 8'h11; cycle();
      chk("late_swap", O_swap, 1);
      chk("inflight_old_bank", O_rd_data, old_exp);

      rand_cycles(3000);
      async_reset_mid_write();
      rd(40);
      chk("post_rst_data", O_rd_data, 0);
      for (int f = 0; f < 256; f++) begin
         I_wr_done = 1; cycle();
         I_rd_sync = 1; cycle();
      end
      chk("cnt_wrap", O_frame_cnt, 0);
      rand_cycles(1500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
